// File: rtl/sync_fifo_pkg.sv
// sync_fifo shared types and defaults.
// Flag bundle and default geometry for the FIFO.
package sync_fifo_pkg;

    localparam int DEF_DBITS = 32;
    localparam int DEF_SIZE  = 4;

    typedef struct packed {
        logic full;
        logic empty;
        logic half_full;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo storage array.
// One synchronous write port, one asynchronous read port.
module fifo_mem #(
    parameter int DBITS = 32,
    parameter int SIZE  = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [SIZE-1:0]  waddr,
    input  logic [DBITS-1:0] wdata,
    input  logic [SIZE-1:0]  raddr,
    output logic [DBITS-1:0] rdata
);

    localparam int DEPTH = 1 << SIZE;

    logic [DBITS-1:0] mem [DEPTH];

    // Store the incoming word; storage is never cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO.
// Pointers, count and flags; storage lives in fifo_mem.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DBITS = DEF_DBITS,
    parameter int SIZE  = DEF_SIZE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] din,
    input  logic             wr,
    input  logic             rd,
    output logic [DBITS-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             half_full,
    output logic             almost_full,
    output logic             almost_empty
);

    localparam int DEPTH = 1 << SIZE;
    localparam logic [SIZE:0] CNT_FULL = (SIZE+1)'(DEPTH);
    localparam logic [SIZE:0] CNT_HALF = (SIZE+1)'(DEPTH / 2);
    localparam logic [SIZE:0] CNT_AF   = (SIZE+1)'(DEPTH - 2);
    localparam logic [SIZE:0] CNT_ONE  = (SIZE+1)'(1);

    logic [SIZE-1:0] wptr;
    logic [SIZE-1:0] rptr;
    logic [SIZE:0]   count;
    logic            wr_ok;
    logic            rd_ok;
    fifo_flags_t     flags;

    // A full FIFO still takes a write when the head is popped the same cycle.
    assign rd_ok = rd && !empty;
    assign wr_ok = wr && (!full || rd);

    // Flags decode only the registered count.
    always_comb begin
        flags = '0;
        flags.full         = (count == CNT_FULL);
        flags.empty        = (count == '0);
        flags.half_full    = (count >= CNT_HALF);
        flags.almost_full  = (count >= CNT_AF);
        flags.almost_empty = (count <= CNT_ONE);
    end

    assign full         = flags.full;
    assign empty        = flags.empty;
    assign half_full    = flags.half_full;
    assign almost_full  = flags.almost_full;
    assign almost_empty = flags.almost_empty;

    // Advance pointers and occupancy on accepted transfers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_ok) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    fifo_mem #(
        .DBITS (DBITS),
        .SIZE  (SIZE)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wptr),
        .wdata (din),
        .raddr (rptr),
        .rdata (dout)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// sync_fifo bench: random traffic against a queue model.
// DBITS=115, SIZE=6.
module tb_sync_fifo;

    localparam int DW    = 115;
    localparam int SZ    = 6;
    localparam int DEPTH = 1 << SZ;

    logic          clk;
    logic          reset;
    logic [DW-1:0] din;
    logic          wr;
    logic          rd;
    logic [DW-1:0] dout;
    logic          full;
    logic          empty;
    logic          half_full;
    logic          almost_full;
    logic          almost_empty;

    int n_cmp;
    int n_bad;

    logic [DW-1:0] q[$];
    logic [DW-1:0] words[DEPTH];

    sync_fifo #(
        .DBITS (DW),
        .SIZE  (SZ)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .din          (din),
        .wr           (wr),
        .rd           (rd),
        .dout         (dout),
        .full         (full),
        .empty        (empty),
        .half_full    (half_full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    // Compare every output against what the model's occupancy implies.
    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ".full"},  DW'(full),         DW'(n == DEPTH));
        chk({tag, ".empty"}, DW'(empty),        DW'(n == 0));
        chk({tag, ".hf"},    DW'(half_full),    DW'(n >= DEPTH / 2));
        chk({tag, ".af"},    DW'(almost_full),  DW'(n >= DEPTH - 2));
        chk({tag, ".ae"},    DW'(almost_empty), DW'(n <= 1));
        if (n > 0) begin
            chk({tag, ".dout"}, dout, q[0]);
        end
    endtask

    // One clock of traffic; the model applies the acceptance rules.
    task automatic step(input string tag, input logic w, input logic r,
                        input logic [DW-1:0] d);
        int  n;
        bit  acc_w;
        bit  acc_r;
        wr  = w;
        rd  = r;
        din = d;
        n   = q.size();
        acc_r = r && (n > 0);
        acc_w = w && ((n < DEPTH) || r);
        @(posedge clk);
        if (acc_r) begin
            void'(q.pop_front());
        end
        if (acc_w) begin
            q.push_back(d);
        end
        #1;
        wr = 1'b0;
        rd = 1'b0;
        check_all(tag);
    endtask

    initial begin
        logic [DW-1:0] w;
        logic [DW-1:0] hd;
        int            exp_cnt;
        n_cmp = 0;
        n_bad = 0;
        wr    = 1'b0;
        rd    = 1'b0;
        din   = '0;
        reset = 1'b0;

        // Reset held
        repeat (3) @(posedge clk);
        #1;
        check_all("rst_hold");
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all("rst_idle");

        // Single word
        step("single_wr", 1'b1, 1'b0, DW'(16'h1234));
        chk("single_dout", dout, DW'(16'h1234));
        chk("single_ae", DW'(almost_empty), DW'(1));
        step("single_rd", 1'b0, 1'b1, '0);
        chk("single_empty", DW'(empty), DW'(1));

        // Fill with distinct words
        for (int i = 0; i < DEPTH; i++) begin
            w = rnd();
            w[7:0] = 8'(i);
            words[i] = w;
            step("fill", 1'b1, 1'b0, w);
            chk("fill_hf", DW'(half_full), DW'(i + 1 >= 32));
            chk("fill_af", DW'(almost_full), DW'(i + 1 >= 62));
            chk("fill_full", DW'(full), DW'(i + 1 >= 64));
        end
        step("over_wr", 1'b1, 1'b0, rnd());
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_word", dout, words[i]);
            step("drain", 1'b0, 1'b1, '0);
        end
        chk("drain_empty", DW'(empty), DW'(1));

        // wr+rd at full
        for (int i = 0; i < DEPTH; i++) begin
            step("refill", 1'b1, 1'b0, rnd());
        end
        hd = q[1];
        w  = rnd();
        step("full_wr_rd", 1'b1, 1'b1, w);
        chk("full_wr_rd_full", DW'(full), DW'(1));
        chk("full_wr_rd_head", dout, hd);
        chk("full_wr_rd_tail", q[DEPTH-1], w);
        while (q.size() > 0) begin
            step("drain2", 1'b0, 1'b1, '0);
        end

        // wr+rd at empty
        w = rnd();
        step("empty_wr_rd", 1'b1, 1'b1, w);
        chk("empty_wr_rd_dout", dout, w);
        chk("empty_wr_rd_ae", DW'(almost_empty), DW'(1));
        chk("empty_wr_rd_e", DW'(empty), DW'(0));
        step("empty_pop", 1'b0, 1'b1, '0);

        // Streaming with a one-cycle lagged pop across wraps
        step("stream0", 1'b1, 1'b0, rnd());
        for (int i = 1; i < 200; i++) begin
            step("stream", 1'b1, 1'b1, rnd());
        end
        step("stream_end", 1'b0, 1'b1, '0);
        chk("stream_empty", DW'(empty), DW'(1));

        // Random mixed traffic
        for (int i = 0; i < 1500; i++) begin
            step("rand", 1'($urandom_range(0, 99) < 55),
                 1'($urandom_range(0, 99) < 45), rnd());
        end
        while (q.size() > 0) begin
            step("drain3", 1'b0, 1'b1, '0);
        end

        // Mid-operation asynchronous reset
        for (int i = 0; i < 10; i++) begin
            step("pre_rst", 1'b1, 1'b0, rnd());
        end
        exp_cnt = q.size();
        chk("pre_rst_cnt", DW'(almost_empty), DW'(exp_cnt <= 1));
        #2;
        reset = 1'b0;
        #1;
        q.delete();
        chk("async_rst_empty", DW'(empty), DW'(1));
        check_all("async_rst");
        #3;
        reset = 1'b1;
        @(negedge clk);
        step("post_rst_wr", 1'b1, 1'b0, DW'(12'hABC));
        chk("post_rst_dout", dout, DW'(12'hABC));
        step("post_rst_rd", 1'b0, 1'b1, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
